io_dev_decoder: RTL and testbench

//  Sits directly downstream of the I/O bridge master port. It decodes the registered I/O

---
 rtl/io_pkg.sv | 14 +
 rtl/io_timeout_ctr.sv | 29 ++
 rtl/io_dev_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_io_dev_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and address-field constants for the I/O device decoder.
// The optional timeout logic is controlled by the IO_TIMEOUT_EN macro in io_dev_decoder.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } io_dec_state_t;

  localparam int unsigned IO_SLOT_LSB = 16;
  localparam int unsigned IO_SLOT_W   = 4;

endpackage

// File: rtl/io_timeout_ctr.sv
// Saturating 16-bit REQ-cycle counter; done flags the cycle on which the device wait expires.
// Instantiated by io_dev_decoder only when IO_TIMEOUT_EN is defined.
module io_timeout_ctr #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [15:0] FireCnt = 16'(TO_CYCLES - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign done = en && (r_cnt == FireCnt);

endmodule

// File: rtl/io_dev_decoder.sv
// Decodes the bridge address into one-hot device selects, re-registers the request and
// returns one muxed ack/data. Define IO_TIMEOUT_EN to build the REQ timeout counter.
module io_dev_decoder
  import io_pkg::*;
#(
  parameter int unsigned NDEV      = 8,
  parameter int unsigned TO_CYCLES = 255,
  parameter logic [31:0] ERR_DAT   = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_cyc_i,
  input  logic               s_stb_i,
  input  logic               s_we_i,
  input  logic [3:0]         s_sel_i,
  input  logic [31:0]        s_adr_i,
  input  logic [31:0]        s_dat_i,
  output logic               s_ack_o,
  output logic               s_err_o,
  output logic               s_stall_o,
  output logic [31:0]        s_dat_o,
  output logic [NDEV-1:0]    dev_cs_o,
  output logic               dev_cyc_o,
  output logic               dev_stb_o,
  output logic               dev_we_o,
  output logic [3:0]         dev_sel_o,
  output logic [31:0]        dev_adr_o,
  output logic [31:0]        dev_dat_o,
  input  logic [NDEV-1:0]    dev_ack_i,
  input  logic [NDEV*32-1:0] dev_dat_i
);

  localparam int unsigned          IdxW    = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [IO_SLOT_W:0]   NdevLim = (IO_SLOT_W + 1)'(NDEV);

  io_dec_state_t r_state, w_state_d;

  logic [IO_SLOT_W-1:0] r_slot, w_slot_d;
  logic                 r_ack, w_ack_d;
  logic                 r_err, w_err_d;
  logic                 r_stall, w_stall_d;
  logic [31:0]          r_dat, w_dat_d;
  logic [NDEV-1:0]      r_cs, w_cs_d;
  logic                 r_dev_cyc, w_dev_cyc_d;
  logic                 r_dev_stb, w_dev_stb_d;
  logic                 r_dev_we, w_dev_we_d;
  logic [3:0]           r_dev_sel, w_dev_sel_d;
  logic [31:0]          r_dev_adr, w_dev_adr_d;
  logic [31:0]          r_dev_dat, w_dev_dat_d;

  logic                 w_accept;
  logic [IO_SLOT_W-1:0] w_adr_slot;
  logic                 w_mapped;
  logic [IdxW-1:0]      w_idx;
  logic                 w_sel_ack;
  logic [31:0]          w_sel_dat;
  logic                 w_dev_clr;
  logic                 w_to_done;

  // A still-high ack from an aborted cycle must not be mistaken for the next one's ack.
  assign w_accept   = s_cyc_i & s_stb_i & ~|dev_ack_i;
  assign w_adr_slot = s_adr_i[IO_SLOT_LSB +: IO_SLOT_W];
  assign w_mapped   = ({1'b0, w_adr_slot} < NdevLim);
  assign w_idx      = r_slot[IdxW-1:0];
  assign w_sel_ack  = dev_ack_i[w_idx];
  assign w_sel_dat  = dev_dat_i[{w_idx, 5'd0} +: 32];

`ifdef IO_TIMEOUT_EN
  logic w_to_clr;
  logic w_to_en;

  assign w_to_clr = (r_state == IDLE) && (w_state_d == REQ);
  assign w_to_en  = (r_state == REQ);

  io_timeout_ctr #(
    .TO_CYCLES (TO_CYCLES)
  ) u_timeout_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (w_to_clr),
    .en     (w_to_en),
    .done   (w_to_done)
  );
`else
  assign w_to_done = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_slot_d    = r_slot;
    w_ack_d     = r_ack;
    w_err_d     = r_err;
    w_dat_d     = r_dat;
    w_cs_d      = r_cs;
    w_dev_cyc_d = r_dev_cyc;
    w_dev_stb_d = r_dev_stb;
    w_dev_we_d  = r_dev_we;
    w_dev_sel_d = r_dev_sel;
    w_dev_adr_d = r_dev_adr;
    w_dev_dat_d = r_dev_dat;
    w_dev_clr   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_slot_d = w_adr_slot;
          if (w_mapped) begin
            w_cs_d                    = '0;
            w_cs_d[w_adr_slot[IdxW-1:0]] = 1'b1;
            w_dev_cyc_d               = 1'b1;
            w_dev_stb_d               = 1'b1;
            w_dev_we_d                = s_we_i;
            w_dev_sel_d               = s_sel_i;
            w_dev_adr_d               = s_adr_i;
            w_dev_dat_d               = s_dat_i;
            w_state_d                 = REQ;
          end else begin
            w_ack_d   = 1'b1;
            w_err_d   = 1'b1;
            w_dat_d   = ERR_DAT;
            w_state_d = ACK;
          end
        end
      end
      REQ: begin
        if (w_sel_ack) begin
          w_dat_d   = w_sel_dat;
          w_ack_d   = 1'b1;
          w_err_d   = 1'b0;
          w_dev_clr = 1'b1;
          w_state_d = ACK;
        end else if (!s_cyc_i) begin
          w_dat_d   = '0;
          w_dev_clr = 1'b1;
          w_state_d = IDLE;
        end else if (w_to_done) begin
          w_ack_d   = 1'b1;
          w_err_d   = 1'b1;
          w_dat_d   = ERR_DAT;
          w_dev_clr = 1'b1;
          w_state_d = ACK;
        end
      end
      ACK: begin
        if (!s_stb_i) begin
          w_ack_d   = 1'b0;
          w_err_d   = 1'b0;
          w_dat_d   = '0;
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    if (w_dev_clr) begin
      w_cs_d      = '0;
      w_dev_cyc_d = 1'b0;
      w_dev_stb_d = 1'b0;
      w_dev_we_d  = 1'b0;
      w_dev_sel_d = '0;
      w_dev_adr_d = '0;
      w_dev_dat_d = '0;
    end

    w_stall_d = (w_state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_stall   <= 1'b0;
      r_dat     <= '0;
      r_cs      <= '0;
      r_dev_cyc <= 1'b0;
      r_dev_stb <= 1'b0;
      r_dev_we  <= 1'b0;
      r_dev_sel <= '0;
      r_dev_adr <= '0;
      r_dev_dat <= '0;
    end else begin
      r_state   <= w_state_d;
      r_slot    <= w_slot_d;
      r_ack     <= w_ack_d;
      r_err     <= w_err_d;
      r_stall   <= w_stall_d;
      r_dat     <= w_dat_d;
      r_cs      <= w_cs_d;
      r_dev_cyc <= w_dev_cyc_d;
      r_dev_stb <= w_dev_stb_d;
      r_dev_we  <= w_dev_we_d;
      r_dev_sel <= w_dev_sel_d;
      r_dev_adr <= w_dev_adr_d;
      r_dev_dat <= w_dev_dat_d;
    end
  end

  assign s_ack_o   = r_ack;
  assign s_err_o   = r_err;
  assign s_stall_o = r_stall;
  assign s_dat_o   = r_dat;
  assign dev_cs_o  = r_cs;
  assign dev_cyc_o = r_dev_cyc;
  assign dev_stb_o = r_dev_stb;
  assign dev_we_o  = r_dev_we;
  assign dev_sel_o = r_dev_sel;
  assign dev_adr_o = r_dev_adr;
  assign dev_dat_o = r_dev_dat;

endmodule

// File: tb/tb_io_dev_decoder.sv
// Directed bench for io_dev_decoder with a response scoreboard; define IO_TIMEOUT_EN to
// exercise the timeout path with TO_CYCLES=16.
module tb_io_dev_decoder;

  localparam int unsigned NDEV = 8;
`ifdef IO_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 16;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif
  localparam logic [31:0] ERR_DAT = 32'hBADD0E55;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_cyc, s_stb, s_we;
  logic [3:0]         s_sel;
  logic [31:0]        s_adr, s_dat_w;
  logic               s_ack_o, s_err_o, s_stall_o;
  logic [31:0]        s_dat_o;
  logic [NDEV-1:0]    dev_cs_o;
  logic               dev_cyc_o, dev_stb_o, dev_we_o;
  logic [3:0]         dev_sel_o;
  logic [31:0]        dev_adr_o, dev_dat_o;
  logic [NDEV-1:0]    dev_ack;
  logic [NDEV*32-1:0] dev_dat;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  wire dev_out_or = |{dev_cs_o, dev_cyc_o, dev_stb_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o};
  wire all_out_or = dev_out_or | (|{s_ack_o, s_err_o, s_stall_o, s_dat_o});

  always #5 clk = ~clk;

  io_dev_decoder #(
    .NDEV      (NDEV),
    .TO_CYCLES (TO_CYCLES),
    .ERR_DAT   (ERR_DAT)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_cyc_i   (s_cyc),
    .s_stb_i   (s_stb),
    .s_we_i    (s_we),
    .s_sel_i   (s_sel),
    .s_adr_i   (s_adr),
    .s_dat_i   (s_dat_w),
    .s_ack_o   (s_ack_o),
    .s_err_o   (s_err_o),
    .s_stall_o (s_stall_o),
    .s_dat_o   (s_dat_o),
    .dev_cs_o  (dev_cs_o),
    .dev_cyc_o (dev_cyc_o),
    .dev_stb_o (dev_stb_o),
    .dev_we_o  (dev_we_o),
    .dev_sel_o (dev_sel_o),
    .dev_adr_o (dev_adr_o),
    .dev_dat_o (dev_dat_o),
    .dev_ack_i (dev_ack),
    .dev_dat_i (dev_dat)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat);
    s_cyc   = 1'b1;
    s_stb   = 1'b1;
    s_we    = we;
    s_sel   = sel;
    s_adr   = adr;
    s_dat_w = dat;
  endtask

  task automatic drop_bus();
    s_cyc = 1'b0;
    s_stb = 1'b0;
  endtask

  task automatic dev_respond(input int n, input logic [31:0] d);
    dev_dat[32*n +: 32] = d;
    dev_ack             = '0;
    dev_ack[n]          = 1'b1;
  endtask

  // Waits for s_ack_o, then checks it against the oldest scoreboard entry.
  task automatic wait_resp(input string tag, input int budget, output int lat);
    exp_t e;
    lat = 0;
    while (!s_ack_o && lat < budget) begin
      step();
      lat++;
    end
    chk({tag, "_ack"}, 64'(s_ack_o), 64'd1);
    chk({tag, "_sb_entry"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.dat = 'x;
      e.err = 'x;
    end
    chk({tag, "_dat"}, 64'(s_dat_o), 64'(e.dat));
    chk({tag, "_err"}, 64'(s_err_o), 64'(e.err));
  endtask

  initial begin
    int lat;
    rst_n   = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    dev_ack = '0;
    dev_dat = '0;
    repeat (3) step();
    chk("reset_outputs", 64'(all_out_or), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_no_stall", 64'(s_stall_o), 64'd0);

    // Read slot 3, stray ack on slot 5 ignored, device acks two cycles after strobe.
    req(1'b0, 4'hF, 32'hFD030010, 32'h0);
    sb.push_back('{dat: 32'h12345678, err: 1'b0});
    step();
    chk("rd3_stb", 64'(dev_stb_o), 64'd1);
    chk("rd3_cyc", 64'(dev_cyc_o), 64'd1);
    chk("rd3_cs", 64'(dev_cs_o), 64'h08);
    chk("rd3_adr", 64'(dev_adr_o), 64'hFD030010);
    chk("rd3_we", 64'(dev_we_o), 64'd0);
    chk("rd3_stall", 64'(s_stall_o), 64'd1);
    dev_respond(5, 32'h11111111);
    step();
    chk("rd3_stray_ack_ignored", 64'(s_ack_o), 64'd0);
    chk("rd3_stb_held", 64'(dev_stb_o), 64'd1);
    dev_respond(3, 32'h12345678);
    wait_resp("rd3", 4, lat);
    chk("rd3_latency", 64'(lat), 64'd1);
    chk("rd3_dev_cleared", 64'(dev_out_or), 64'd0);
    dev_ack = '0;
    repeat (2) step();
    chk("rd3_ack_hold", 64'(s_ack_o), 64'd1);
    chk("rd3_dat_hold", 64'(s_dat_o), 64'h12345678);
    drop_bus();
    step();
    chk("rd3_ack_drop", 64'(s_ack_o), 64'd0);
    chk("rd3_dat_drop", 64'(s_dat_o), 64'd0);
    chk("rd3_idle", 64'(s_stall_o), 64'd0);

    // Write slot 0; a write still returns the device data.
    req(1'b1, 4'b0011, 32'hFD000004, 32'hA5A5A5A5);
    sb.push_back('{dat: 32'hCAFEF00D, err: 1'b0});
    step();
    chk("wr0_we", 64'(dev_we_o), 64'd1);
    chk("wr0_sel", 64'(dev_sel_o), 64'h3);
    chk("wr0_dat", 64'(dev_dat_o), 64'hA5A5A5A5);
    chk("wr0_cs", 64'(dev_cs_o), 64'h01);
    dev_respond(0, 32'hCAFEF00D);
    wait_resp("wr0", 4, lat);
    chk("wr0_dev_cleared", 64'(dev_out_or), 64'd0);
    dev_ack = '0;
    drop_bus();
    step();
    chk("wr0_idle", 64'(s_ack_o), 64'd0);

    // Last mapped slot.
    req(1'b0, 4'hF, 32'hFD070000, 32'h0);
    sb.push_back('{dat: 32'h77770007, err: 1'b0});
    step();
    chk("rd7_cs", 64'(dev_cs_o), 64'h80);
    dev_respond(7, 32'h77770007);
    wait_resp("rd7", 4, lat);
    dev_ack = '0;
    drop_bus();
    step();

    // Unmapped slots 9 and 8: immediate error ack, no device strobe.
    req(1'b0, 4'hF, 32'hFD090000, 32'h0);
    sb.push_back('{dat: ERR_DAT, err: 1'b1});
    wait_resp("unm9", 4, lat);
    chk("unm9_latency", 64'(lat), 64'd1);
    chk("unm9_no_stb", 64'(dev_out_or), 64'd0);
    step();
    chk("unm9_no_stb_later", 64'(dev_stb_o), 64'd0);
    drop_bus();
    step();
    chk("unm9_idle", 64'(s_ack_o), 64'd0);
    req(1'b1, 4'hF, 32'hFD080000, 32'h12121212);
    sb.push_back('{dat: ERR_DAT, err: 1'b1});
    wait_resp("unm8", 4, lat);
    chk("unm8_no_stb", 64'(dev_stb_o), 64'd0);
    drop_bus();
    step();

    // Silent device on slot 4.
    req(1'b0, 4'hF, 32'hFD040000, 32'h0);
`ifdef IO_TIMEOUT_EN
    sb.push_back('{dat: ERR_DAT, err: 1'b1});
    step();
    chk("to_stb", 64'(dev_stb_o), 64'd1);
    wait_resp("timeout", 40, lat);
    chk("to_latency", 64'(lat), 64'd16);
    chk("to_dev_cleared", 64'(dev_out_or), 64'd0);
    drop_bus();
    step();
`else
    step();
    repeat (300) step();
    chk("silent_no_ack", 64'(s_ack_o), 64'd0);
    chk("silent_stb_held", 64'(dev_stb_o), 64'd1);
    drop_bus();
    step();
    chk("silent_abort_clr", 64'(dev_out_or), 64'd0);
`endif

    // Abort in the third REQ cycle, then a late ack blocks the next request.
    req(1'b0, 4'hF, 32'hFD020000, 32'h0);
    step();
    step();
    step();
    chk("abort_in_req", 64'(dev_stb_o), 64'd1);
    drop_bus();
    step();
    chk("abort_dev_cleared", 64'(dev_out_or), 64'd0);
    chk("abort_no_ack", 64'(s_ack_o), 64'd0);
    chk("abort_idle", 64'(s_stall_o), 64'd0);
    dev_respond(2, 32'h22222222);
    req(1'b0, 4'hF, 32'hFD010000, 32'h0);
    step();
    step();
    chk("late_ack_blocks", 64'(dev_stb_o), 64'd0);
    chk("late_ack_no_s_ack", 64'(s_ack_o), 64'd0);
    dev_ack = '0;
    step();
    chk("after_late_stb", 64'(dev_stb_o), 64'd1);
    chk("after_late_cs", 64'(dev_cs_o), 64'h02);
    sb.push_back('{dat: 32'h01010101, err: 1'b0});
    dev_respond(1, 32'h01010101);
    wait_resp("rd1", 4, lat);
    dev_ack = '0;
    drop_bus();
    step();

    // Reset while holding an ack.
    req(1'b0, 4'hF, 32'hFD060000, 32'h0);
    sb.push_back('{dat: 32'h600D0006, err: 1'b0});
    step();
    dev_respond(6, 32'h600D0006);
    wait_resp("rd6", 4, lat);
    dev_ack = '0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_ack_reset", 64'(all_out_or), 64'd0);
    drop_bus();
    step();
    rst_n = 1'b1;
    req(1'b1, 4'h1, 32'hFD050008, 32'h55AA55AA);
    sb.push_back('{dat: 32'h05050505, err: 1'b0});
    step();
    chk("post_rst_cs", 64'(dev_cs_o), 64'h20);
    chk("post_rst_dat", 64'(dev_dat_o), 64'h55AA55AA);
    dev_respond(5, 32'h05050505);
    wait_resp("post_rst", 4, lat);
    dev_ack = '0;
    drop_bus();
    step();
    chk("post_rst_idle", 64'(s_ack_o), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
